// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and synchronizer depth.
package fifo_pkg;

    localparam int unsigned FIFO_SYNC_STAGES = 2;
    localparam int unsigned FIFO_GW          = 32;

    typedef logic [FIFO_GW-1:0] fifo_word_t;

    function automatic fifo_word_t fifo_mask(input int unsigned w);
        fifo_word_t m;
        m = (w >= FIFO_GW) ? '1 : ((fifo_word_t'(1) << w) - fifo_word_t'(1));
        return m;
    endfunction

    function automatic fifo_word_t bin2gray(input fifo_word_t b, input int unsigned w);
        fifo_word_t bm;
        bm = b & fifo_mask(w);
        return (bm >> 1) ^ bm;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic fifo_word_t gray2bin(input fifo_word_t g, input int unsigned w);
        fifo_word_t gm;
        fifo_word_t b;
        gm = g & fifo_mask(w);
        b  = gm;
        for (int unsigned i = 1; i < FIFO_GW; i++) begin
            b = b ^ (gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Vector multi-flop synchronizer (FIFO_SYNC_STAGES deep) with async active-low reset.
module fifo_sync2
    import fifo_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [FIFO_SYNC_STAGES];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < FIFO_SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < FIFO_SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[FIFO_SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer / full-flag controller of the dual-clock FIFO (w_clk domain).
// Define FIFO_WLEVEL_EN to build the fill-level and almost_full logic.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                       w_clk,
    input  logic                       w_rst_n,
    input  logic                       wr_rq,
    input  logic [$clog2(DEPTH):0]     rptr_gray,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH)-1:0]   waddr,
    output logic [$clog2(DEPTH):0]     wptr_gray,
    output logic                       full,
    output logic                       wr_en,
    output logic [$clog2(DEPTH):0]     wlevel,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    if ((DEPTH != (1 << AW)) || (DEPTH < 4) || (AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_cfg
        $error("fifo_wptr_full: invalid DEPTH/AF_LEVEL");
    end

    logic [AW:0] r_wbin;
    logic [AW:0] r_wgray;
    logic [AW:0] r_wlevel;
    logic        r_full;
    logic        r_af;
    logic        r_ovf;

    logic [AW:0] w_rq2_gray;
    logic [AW:0] w_wbin_next;
    logic [AW:0] w_gray_next;
    logic [AW:0] w_full_cmp;
    logic [AW:0] w_wlevel_next;
    logic        w_wr_en;
    logic        w_full_next;
    logic        w_af_next;

    fifo_sync2 #(.W(AW + 1)) u_rsync (
        .i_clk   (w_clk),
        .i_rst_n (w_rst_n),
        .i_d     (rptr_gray),
        .o_q     (w_rq2_gray)
    );

    assign w_wr_en     = wr_rq & ~r_full;
    assign w_wbin_next = r_wbin + (AW + 1)'(w_wr_en);
    assign w_gray_next = (AW + 1)'(bin2gray(fifo_word_t'(w_wbin_next), AW + 1));

    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    assign w_full_cmp  = {~w_rq2_gray[AW:AW-1], w_rq2_gray[AW-2:0]};
    assign w_full_next = (w_gray_next == w_full_cmp);

`ifdef FIFO_WLEVEL_EN
    logic [AW:0] w_rbin_sync;
    assign w_rbin_sync   = (AW + 1)'(gray2bin(fifo_word_t'(w_rq2_gray), AW + 1));
    assign w_wlevel_next = w_wbin_next - w_rbin_sync;
    assign w_af_next     = (w_wlevel_next >= (AW + 1)'(AF_LEVEL));
`else
    assign w_wlevel_next = '0;
    assign w_af_next     = w_full_next;
`endif

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_wlevel <= '0;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_gray_next;
            r_wlevel <= w_wlevel_next;
            r_full   <= w_full_next;
            r_af     <= w_af_next;
            if (wr_rq & r_full) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign waddr       = r_wbin[AW-1:0];
    assign wptr_gray   = r_wgray;
    assign full        = r_full;
    assign wr_en       = w_wr_en;
    assign wlevel      = r_wlevel;
    assign almost_full = r_af;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomized self-checking bench for fifo_wptr_full against a count-based occupancy model.
module tb_fifo_wptr_full;

    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AW       = 3;
    localparam int PW       = 16;

    logic          w_clk   = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          wr_rq   = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW:0]   rptr_gray = '0;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          full;
    logic          wr_en;
    logic [AW:0]   wlevel;
    logic          almost_full;
    logic          overflow;

    fifo_wptr_full #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .wr_rq       (wr_rq),
        .rptr_gray   (rptr_gray),
        .ovf_clr     (ovf_clr),
        .waddr       (waddr),
        .wptr_gray   (wptr_gray),
        .full        (full),
        .wr_en       (wr_en),
        .wlevel      (wlevel),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: total writes accepted and total reads issued; the write side sees reads 2 edges late.
    int wcnt, rcnt, m_lvl;
    bit m_full, m_ovf;
    int rq[$];
    bit chk_en = 1'b0;

    function automatic int gray(input int n);
        return n ^ (n >> 1);
    endfunction

    task automatic model_reset();
        wcnt = 0; rcnt = 0; m_lvl = 0; m_full = 0; m_ovf = 0;
        rq = '{0, 0};
    endtask

    task automatic drive_rptr();
        rptr_gray = (AW + 1)'(gray(rcnt % PW));
    endtask

    task automatic model_edge();
        int rs;
        bit acc;
        rs = rq[0];
        void'(rq.pop_front());
        rq.push_back(rcnt);
        acc = wr_rq && !m_full;
        if (wr_rq && m_full) m_ovf = 1;
        else if (ovf_clr)    m_ovf = 0;
        if (acc) wcnt++;
        m_lvl  = wcnt - rs;
        m_full = (m_lvl == DEPTH);
    endtask

    task automatic step();
        @(posedge w_clk);
        if (w_rst_n) model_edge();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    logic [AW:0] prev_gray = '0;
    initial begin
        forever begin
            @(negedge w_clk);
            if (!w_rst_n) begin
                prev_gray = '0;
            end else if (chk_en) begin
                check("waddr", int'(waddr), wcnt % DEPTH);
                check("wptr_gray", int'(wptr_gray), gray(wcnt % PW));
                check("full", int'(full), int'(m_full));
                check("wr_en", int'(wr_en), int'(wr_rq && !m_full));
                check("overflow", int'(overflow), int'(m_ovf));
`ifdef FIFO_WLEVEL_EN
                check("wlevel", int'(wlevel), m_lvl);
                check("almost_full", int'(almost_full), int'(m_lvl >= AF_LEVEL));
`else
                check("wlevel", int'(wlevel), 0);
                check("almost_full", int'(almost_full), int'(m_full));
`endif
                if (wptr_gray != prev_gray)
                    check("gray_onebit", $countones(wptr_gray ^ prev_gray), 1);
                prev_gray = wptr_gray;
            end
        end
    end

    int gtab[9] = '{0, 1, 3, 2, 6, 7, 5, 4, 12};

    initial begin
        model_reset();
        drive_rptr();
        repeat (3) @(posedge w_clk);
        #1;
        check("rst_waddr", int'(waddr), 0);
        check("rst_wptr_gray", int'(wptr_gray), 0);
        check("rst_full", int'(full), 0);
        check("rst_wlevel", int'(wlevel), 0);
        check("rst_almost_full", int'(almost_full), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_wr_en", int'(wr_en), 0);
        #1;
        w_rst_n = 1'b1;
        chk_en  = 1'b1;
        wr_rq   = 1'b1;

        // Fill to DEPTH with the read pointer parked at 0.
        for (int k = 1; k <= 8; k++) begin
            step();
            check("fill_waddr", int'(waddr), k % 8);
            check("fill_wptr_gray", int'(wptr_gray), gtab[k]);
            check("fill_full", int'(full), int'(k == 8));
`ifdef FIFO_WLEVEL_EN
            check("fill_wlevel", int'(wlevel), k);
            check("fill_almost_full", int'(almost_full), int'(k >= 6));
`else
            check("fill_wlevel", int'(wlevel), 0);
            check("fill_almost_full", int'(almost_full), int'(k == 8));
`endif
        end
        #2;
        check("full_wr_en", int'(wr_en), 0);
        step();
        check("ovf_waddr", int'(waddr), 0);
        check("ovf_wptr_gray", int'(wptr_gray), 12);
        check("ovf_set", int'(overflow), 1);
        #1;
        wr_rq = 1'b0; ovf_clr = 1'b1;
        step();
        check("ovf_clr", int'(overflow), 0);
        #1;
        ovf_clr = 1'b0; rcnt = 1; drive_rptr();
        step();
        check("read_full_e1", int'(full), 1);
        step();
        step();
        check("read_full_e3", int'(full), 0);
`ifdef FIFO_WLEVEL_EN
        check("read_wlevel", int'(wlevel), 7);
`endif

        // Drain, then 40 writes each matched by a read advance (crosses the pointer wrap).
        while (rcnt < wcnt) begin
            #1; rcnt++; drive_rptr();
            step();
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            wr_rq = 1'b1;
            if (rcnt < wcnt) rcnt++;
            drive_rptr();
            step();
        end

        // Random traffic with an asynchronous reset dropped in mid-burst.
        for (int i = 0; i < 400; i++) begin
            #1;
            if (i == 200) begin
                wr_rq   = 1'b0;
                ovf_clr = 1'b0;
                w_rst_n = 1'b0;
                #1;
                check("arst_waddr", int'(waddr), 0);
                check("arst_wptr_gray", int'(wptr_gray), 0);
                check("arst_full", int'(full), 0);
                check("arst_wlevel", int'(wlevel), 0);
                check("arst_almost_full", int'(almost_full), 0);
                check("arst_overflow", int'(overflow), 0);
                model_reset();
                drive_rptr();
                repeat (2) @(posedge w_clk);
                #2;
                w_rst_n = 1'b1;
                wr_rq   = 1'b1;
                #1;
                check("post_rst_waddr0", int'(waddr), 0);
                step();
                check("post_rst_waddr1", int'(waddr), 1);
                #1;
            end
            wr_rq   = (($urandom % 100) < 70);
            ovf_clr = (($urandom % 8) == 0);
            if ((rcnt < wcnt) && (($urandom % 100) < 45)) rcnt++;
            drive_rptr();
            step();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
